// File: rtl/blink_pkg.sv
// Shared encodings and wr_data field layout for the multi-channel LED sequencer.
// Config word layout: {mode, half, count}, count in the least significant bits.
package blink_pkg;

    localparam int MODE_W     = 2;
    localparam int DEF_HALF_W = 8;
    localparam int DEF_CNT_W  = 4;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_BURST = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_ON   = 2'd1,
        S_HIGH = 2'd2,
        S_LOW  = 2'd3
    } state_e;

    function automatic int cfg_w(input int half_w, input int cnt_w);
        return MODE_W + half_w + cnt_w;
    endfunction

    function automatic int half_lsb(input int cnt_w);
        return cnt_w;
    endfunction

    function automatic int mode_lsb(input int half_w, input int cnt_w);
        return half_w + cnt_w;
    endfunction

endpackage

// File: rtl/blink_chan.sv
// One LED channel: config registers, phase counter and burst counter.
// Advances only on prescaler ticks; a write always restarts the channel.
module blink_chan
    import blink_pkg::*;
#(
    parameter int HALF_W = DEF_HALF_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             tick,
    input  logic                             wr,
    input  logic [cfg_w(HALF_W, CNT_W)-1:0]  cfg,
    output logic                             led,
    output logic                             busy,
    output logic                             done
);

    localparam int HALF_LSB = half_lsb(CNT_W);
    localparam int MODE_LSB = mode_lsb(HALF_W, CNT_W);

    mode_e              cfg_mode;
    logic [HALF_W-1:0]  cfg_half;
    logic [HALF_W-1:0]  cfg_half_eff;
    logic [CNT_W-1:0]   cfg_count;

    assign cfg_mode     = mode_e'(cfg[MODE_LSB +: MODE_W]);
    assign cfg_half     = cfg[HALF_LSB +: HALF_W];
    assign cfg_count    = cfg[0 +: CNT_W];
    // A zero half-period would never end a phase; run it as one tick instead.
    assign cfg_half_eff = (cfg_half == '0) ? HALF_W'(1) : cfg_half;

    state_e             state_reg;
    mode_e              mode_reg;
    logic [HALF_W-1:0]  half_reg;
    logic [HALF_W-1:0]  phase_reg;
    logic [CNT_W-1:0]   remain_reg;
    logic               led_reg;
    logic               busy_reg;
    logic               done_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= S_OFF;
            mode_reg   <= MODE_OFF;
            half_reg   <= '0;
            phase_reg  <= '0;
            remain_reg <= '0;
            led_reg    <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (wr) begin
                // The write takes priority over any phase end in the same cycle.
                mode_reg   <= cfg_mode;
                half_reg   <= cfg_half_eff;
                phase_reg  <= cfg_half_eff;
                remain_reg <= cfg_count;
                case (cfg_mode)
                    MODE_OFF: begin
                        state_reg <= S_OFF;
                        led_reg   <= 1'b0;
                        busy_reg  <= 1'b0;
                    end
                    MODE_ON: begin
                        state_reg <= S_ON;
                        led_reg   <= 1'b1;
                        busy_reg  <= 1'b0;
                    end
                    MODE_BLINK: begin
                        state_reg <= S_HIGH;
                        led_reg   <= 1'b1;
                        busy_reg  <= 1'b1;
                    end
                    default: begin
                        if (cfg_count == '0) begin
                            state_reg <= S_OFF;
                            led_reg   <= 1'b0;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= S_HIGH;
                            led_reg   <= 1'b1;
                            busy_reg  <= 1'b1;
                        end
                    end
                endcase
            end else if (tick) begin
                case (state_reg)
                    S_HIGH: begin
                        if (phase_reg == HALF_W'(1)) begin
                            state_reg <= S_LOW;
                            phase_reg <= half_reg;
                            led_reg   <= 1'b0;
                        end else begin
                            phase_reg <= phase_reg - 1'b1;
                        end
                    end
                    S_LOW: begin
                        if (phase_reg != HALF_W'(1)) begin
                            phase_reg <= phase_reg - 1'b1;
                        end else if (mode_reg == MODE_BURST && remain_reg == CNT_W'(1)) begin
                            remain_reg <= '0;
                            state_reg  <= S_OFF;
                            busy_reg   <= 1'b0;
                            done_reg   <= 1'b1;
                        end else begin
                            if (mode_reg == MODE_BURST) begin
                                remain_reg <= remain_reg - 1'b1;
                            end
                            state_reg <= S_HIGH;
                            phase_reg <= half_reg;
                            led_reg   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign led  = led_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: rtl/blink_ctrl.sv
// Multi-channel LED sequencer top: shared tick prescaler, write address decode
// and one blink_chan per LED.
module blink_ctrl
    import blink_pkg::*;
#(
    parameter int PRESCALE = 50000,
    parameter int NUM_LEDS = 4,
    parameter int HALF_W   = DEF_HALF_W,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             wr_en,
    input  logic [3:0]                       wr_addr,
    input  logic [cfg_w(HALF_W, CNT_W)-1:0]  wr_data,
    output logic [NUM_LEDS-1:0]              led,
    output logic [NUM_LEDS-1:0]              busy,
    output logic [NUM_LEDS-1:0]              done
);

    localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_reg;
    logic            tick;

    assign tick = (ps_reg == PS_LAST);

    // Free-running; config writes deliberately do not realign it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ps_reg <= '0;
        end else begin
            ps_reg <= tick ? '0 : ps_reg + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_chan
            logic chan_wr;
            assign chan_wr = wr_en && (wr_addr == 4'(gi));

            blink_chan #(
                .HALF_W (HALF_W),
                .CNT_W  (CNT_W)
            ) u_chan (
                .clk    (clk),
                .reset  (reset),
                .tick   (tick),
                .wr     (chan_wr),
                .cfg    (wr_data),
                .led    (led[gi]),
                .busy   (busy[gi]),
                .done   (done[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_blink_ctrl.sv
// Scoreboard bench for blink_ctrl: expected per-edge {led,busy,done} per channel
// is queued when a write is driven and compared as each edge completes.
module tb_blink_ctrl;

    localparam int PS = 4;
    localparam int NL = 4;
    localparam int HW = 8;
    localparam int CW = 4;
    localparam int DW = 2 + HW + CW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic [3:0]    wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [NL-1:0] led;
    logic [NL-1:0] busy;
    logic [NL-1:0] done;

    int checks;
    int failures;
    int cyc;

    typedef struct {
        int         e;
        logic [2:0] v;
        string      name;
    } exp_t;

    exp_t sbq[NL][$];

    blink_ctrl #(
        .PRESCALE (PS),
        .NUM_LEDS (NL),
        .HALF_W   (HW),
        .CNT_W    (CW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .led     (led),
        .busy    (busy),
        .done    (done)
    );

    always #10 clk = ~clk;

    // Edge index since reset release; the prescaler restarts at 0 with it,
    // so a tick lands on every edge whose index is a multiple of PS.
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        exp_t       x;
        logic [2:0] got;
        if (reset) begin
            for (int c = 0; c < NL; c++) begin
                while (sbq[c].size() > 0 && sbq[c][0].e <= cyc) begin
                    x   = sbq[c].pop_front();
                    got = {led[c], busy[c], done[c]};
                    checks++;
                    if (got !== x.v || x.e != cyc) begin
                        failures++;
                        $display("FAIL %s ch=%0d edge=%0d (at %0d) led/busy/done got=%b expected=%b",
                                 x.name, c, x.e, cyc, got, x.v);
                    end else begin
                        $display("ok   %s ch=%0d edge=%0d led/busy/done=%b", x.name, c, cyc, got);
                    end
                end
            end
        end
    end

    // Expected {led,busy,done} after edge e for a write sampled at edge k.
    function automatic logic [2:0] model(input int e, input int k, input int mode,
                                         input int half, input int cnt);
        int h, ft, t1, per, p, fin;
        if (mode == 0) return 3'b000;
        if (mode == 1) return 3'b100;
        if (mode == 3 && cnt == 0) return (e == k) ? 3'b001 : 3'b000;
        h  = (half == 0) ? 1 : half;
        ft = k + 1;
        while (ft % PS != 0) ft++;
        t1  = ft + (h - 1) * PS;
        per = h * PS;
        if (e < t1) return 3'b110;
        p = (e - t1) / per;
        if (mode == 2) return (p % 2 == 0) ? 3'b010 : 3'b110;
        fin = t1 + (2 * cnt - 1) * per;
        if (e < fin)  return (p % 2 == 0) ? 3'b010 : 3'b110;
        if (e == fin) return 3'b001;
        return 3'b000;
    endfunction

    function automatic bit pending();
        for (int c = 0; c < NL; c++) if (sbq[c].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clear_queues();
        for (int c = 0; c < NL; c++) sbq[c].delete();
    endtask

    // Called on a falling edge; returns on the falling edge after edge k.
    task automatic do_write(input int addr, input int mode, input int half, input int cnt,
                            input int span, input string name, output int k);
        wr_en   = 1'b1;
        wr_addr = addr[3:0];
        wr_data = {mode[1:0], half[HW-1:0], cnt[CW-1:0]};
        k       = cyc + 1;
        if (addr < NL) begin
            for (int e = k; e < k + span; e++) begin
                sbq[addr].push_back('{e: e, v: model(e, k, mode, half, cnt), name: name});
            end
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic push_zero(input int ch, input int from, input int n, input string name);
        for (int e = from; e < from + n; e++) sbq[ch].push_back('{e: e, v: 3'b000, name: name});
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (pending() && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (pending()) begin
            failures++;
            $display("FAIL %s_drain: scoreboard still holds entries after %0d cycles, expected empty", name, n);
            clear_queues();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({led, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_hold: led/busy/done=%b expected all 0", {led, busy, done});
        end
        reset = 1'b1;
        for (int c = 0; c < NL; c++) push_zero(c, 1, 50, "reset_idle");
        repeat (50) @(negedge clk);
        drain("reset");
    endtask

    task automatic test_steady_on();
        int k;
        do_write(0, 1, 0, 0, 6, "steady_on", k);
        repeat (5) @(negedge clk);
        checks++;
        if (busy[0] !== 1'b0 || led[0] !== 1'b1) begin
            failures++;
            $display("FAIL steady_on_hold: led0=%b busy0=%b expected led0=1 busy0=0", led[0], busy[0]);
        end
        do_write(0, 0, 0, 0, 4, "steady_off", k);
        repeat (3) @(negedge clk);
        drain("steady");
    endtask

    task automatic test_blink();
        int k;
        do_write(1, 2, 2, 0, 60, "blink", k);
        repeat (59) begin
            @(negedge clk);
            checks++;
            if (busy[1] !== 1'b1) begin
                failures++;
                $display("FAIL blink_busy: busy1=%b at edge %0d expected 1", busy[1], cyc);
            end
        end
        drain("blink");
    endtask

    task automatic test_burst();
        int k, rises, dones;
        logic prev;
        prev = led[2];
        do_write(2, 3, 1, 3, 30, "burst3", k);
        rises = 0;
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            if (i > 0) @(negedge clk);
            if (led[2] && !prev) rises++;
            if (done[2]) dones++;
            prev = led[2];
        end
        checks++;
        if (rises != 3) begin
            failures++;
            $display("FAIL burst_pulses: got %0d high pulses expected 3", rises);
        end
        checks++;
        if (dones != 1) begin
            failures++;
            $display("FAIL burst_done_count: got %0d done pulses expected 1", dones);
        end
        // count = 0: immediate completion, LED never lit.
        do_write(3, 3, 1, 0, 8, "burst0", k);
        rises = 0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            if (led[3]) rises++;
            if (done[3]) dones++;
        end
        checks++;
        if (rises != 0 || dones != 1) begin
            failures++;
            $display("FAIL burst0: lit cycles=%0d done pulses=%0d expected 0 and 1", rises, dones);
        end
        drain("burst");
    endtask

    task automatic test_collision();
        int kp, ft, fin, k, k2, bad;
        kp = cyc + 1;
        ft = kp + 1;
        while (ft % PS != 0) ft++;
        fin = ft + PS;
        do_write(2, 3, 1, 1, fin - kp, "collide_burst", k);
        while (cyc < fin - 1) @(negedge clk);
        do_write(2, 0, 0, 0, 6, "collide_off", k2);
        checks++;
        if (k2 != fin) begin
            failures++;
            $display("FAIL collide_align: write edge %0d expected %0d", k2, fin);
        end
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            if (done[2] || led[2]) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL collide_quiet: %0d cycles with done2 or led2 set expected 0", bad);
        end
        drain("collision");
    endtask

    task automatic test_reset_midburst();
        int k;
        do_write(2, 3, 2, 3, 10, "midburst", k);
        repeat (9) @(negedge clk);
        #5 reset = 1'b0;
        #1;
        checks++;
        if ({led, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_async: led/busy/done=%b expected all 0", {led, busy, done});
        end
        clear_queues();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < NL; c++) push_zero(c, 1, 20, "post_reset");
        repeat (20) @(negedge clk);
        drain("reset_midburst");
    endtask

    task automatic test_invalid_addr();
        int k, kx;
        do_write(0, 1, 0, 0, 20, "inv_ch0_on", k);
        for (int c = 1; c < NL; c++) push_zero(c, k + 1, 19, "inv_idle");
        do_write(4, 0, 0, 0, 0, "inv4", kx);
        do_write(5, 2, 1, 0, 0, "inv5", kx);
        do_write(6, 3, 1, 2, 0, "inv6", kx);
        do_write(15, 1, 0, 0, 0, "inv15", kx);
        repeat (16) @(negedge clk);
        drain("invalid_addr");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_steady_on();
        test_blink();
        test_burst();
        test_collision();
        test_reset_midburst();
        test_invalid_addr();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
